// File: rtl/mem_port_arbiter.sv
// N-channel arbiter onto one shared memory port; request-to-mem 1 cycle, mem_resp-to-ch_resp 1 cycle, one IDLE gap between accesses.
// Channels hold requests until ch_resp; the memory stalls via mem_resp. `ARB_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin.
module mem_port_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*MASK_W-1:0]   ch_byte_enable,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]          ch_resp,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [MASK_W-1:0]          mem_byte_enable,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_resp,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int IDX_W = $clog2(NUM_CH);
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   sum_t;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t              state_q, state_d;
  idx_t                grant_q, grant_d;
  logic                rd_q, rd_d, wr_q, wr_d;
  logic [MASK_W-1:0]   be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [NUM_CH-1:0]   req;
  logic [MASK_W-1:0]   be_arr    [NUM_CH];
  logic [ADDR_W-1:0]   addr_arr  [NUM_CH];
  logic [DATA_W-1:0]   wdata_arr [NUM_CH];
  idx_t                scan_start, pick, cand;
  sum_t                scan_sum;
  logic                found;

  assign req = ch_read | ch_write;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign be_arr[g]    = ch_byte_enable[g*MASK_W +: MASK_W];
    assign addr_arr[g]  = ch_address[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = ch_wdata[g*DATA_W +: DATA_W];
  end

`ifdef ARB_FIXED_PRIO_EN
  assign scan_start = '0;
`else
  idx_t rr_ptr_q, rr_ptr_d;
  assign scan_start = rr_ptr_q;
`endif

  // Circular scan from scan_start; the first requester encountered wins.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_sum = '0;
    cand     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_sum = {1'b0, scan_start} + sum_t'(k);
      if (scan_sum >= sum_t'(NUM_CH)) scan_sum = scan_sum - sum_t'(NUM_CH);
      cand = scan_sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifndef ARB_FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          rd_d    = ch_read[pick];
          wr_d    = ch_write[pick];
          be_d    = be_arr[pick];
          addr_d  = addr_arr[pick];
          wdata_d = wdata_arr[pick];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_resp) begin
          rdata_d = mem_rdata;
          state_d = RESP;
`ifndef ARB_FIXED_PRIO_EN
          rr_ptr_d = (grant_q == idx_t'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      grant_q <= grant_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  // Memory side sees only latched fields, and only while ISSUE; write dominates read.
  always_comb begin
    mem_read        = (state_q == ISSUE) && rd_q && !wr_q;
    mem_write       = (state_q == ISSUE) && wr_q;
    mem_byte_enable = (state_q == ISSUE) ? be_q    : '0;
    mem_address     = (state_q == ISSUE) ? addr_q  : '0;
    mem_wdata       = (state_q == ISSUE) ? wdata_q : '0;
    ch_rdata        = rdata_q;
    ch_resp         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_resp[i] = (state_q == RESP) && (grant_q == idx_t'(i));
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-channel arbiter placing the CPU-side instruction and data ports (plus any future ports, e.g. a prefetcher) onto one shared memory port.
- Successor to the fixed two-port magic-memory arrangement: lets the core run against a single-ported memory or cache.
- Every channel and the memory side use the existing read/write/byte_enable/address/wdata/resp/rdata protocol: a request is held until resp is seen.

Parameters:
NUM_CH, 2, number of requesting channels (>=2); channel 0 = instruction, 1 = data
ADDR_W, 16, address width
DATA_W, 16, data width (multiple of 8)
MASK_W, DATA_W/8, byte-enable width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
ch_read  in  NUM_CH  per-channel read request
ch_write  in  NUM_CH  per-channel write request
ch_byte_enable  in  NUM_CH*MASK_W  per-channel byte mask; channel i at [i*MASK_W +: MASK_W]
ch_address  in  NUM_CH*ADDR_W  per-channel address, same packing
ch_wdata  in  NUM_CH*DATA_W  per-channel write data, same packing
ch_resp  out  NUM_CH  one-cycle completion pulse, one-hot
ch_rdata  out  DATA_W  read data, broadcast, valid while the matching ch_resp bit is high
mem_read  out  1  shared memory read
mem_write  out  1  shared memory write
mem_byte_enable  out  MASK_W  shared memory byte mask
mem_address  out  ADDR_W  shared memory address
mem_wdata  out  DATA_W  shared memory write data
mem_resp  in  1  shared memory completion
mem_rdata  in  DATA_W  shared memory read data

Behaviour:
- Reset: state IDLE, rr_ptr=0, grant=0, all outputs 0, latched request fields 0. Takes effect immediately and asynchronously, including mid-transaction.
- Mid-transaction reset abandons the outstanding access. No ch_resp is issued for it.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - req[i] = ch_read[i] | ch_write[i].
  - If any req is set, pick the first set index scanning rr_ptr, rr_ptr+1, ... modulo NUM_CH.
  - Latch the grant index, read/write, byte_enable, address and wdata into registers, then go to ISSUE.
  - Otherwise stay in IDLE. All mem_* outputs are 0 in IDLE.
- ISSUE:
  - mem_* outputs are driven only from the latched registers; a channel changing its inputs cannot affect an in-flight access.
  - If both read and write were latched, write wins: mem_write=1, mem_read=0.
  - Stay in ISSUE until mem_resp=1.
  - On that edge: capture mem_rdata (for a write, capture whatever mem_rdata holds), set rr_ptr=(grant+1) mod NUM_CH, go to RESP.
- RESP (exactly one cycle):
  - ch_resp[grant]=1, ch_rdata = captured data, mem_read=mem_write=0.
  - Next state is IDLE.
  - The requester must drop or replace its request at the edge ending RESP.
- Latency:
  - Request seen in IDLE at cycle 0 gives mem_* asserted at cycle 1.
  - mem_resp at cycle k (k>=1) gives ch_resp at cycle k+1, and the arbiter is back in IDLE at k+2.
  - Minimum total latency is 2 cycles; the memory port is never driven in two consecutive transactions without one IDLE cycle between them.
- Fairness: with all channels requesting continuously, grants rotate 0,1,...,NUM_CH-1,0,...
- mem_resp outside ISSUE is ignored.
- ch_resp bits other than the grant are always 0.
- ch_rdata holds its last captured value outside RESP.
- rr_ptr wrap: after granting NUM_CH-1, rr_ptr=0.

Optional Feature:
ARB_FIXED_PRIO_EN:
- Defined: the IDLE scan always starts at index 0, so the lowest-index requester wins. rr_ptr is neither used nor updated.
- Undefined (default): round-robin exactly as described above.
- Both builds are otherwise cycle-identical.

Test Plan:
- Single read, NUM_CH=2: ch_read[1]=1, ch_address[1]=16'h0040, memory replies mem_rdata=16'hBEEF in the first ISSUE cycle -> mem_read=1 with mem_address=16'h0040 at cycle 1, ch_resp=2'b10 and ch_rdata=16'hBEEF at cycle 2.
- Simultaneous requests: ch0 reads 16'h0000 and ch1 writes 16'h1234 to 16'h0100 with mask 2'b11, both held -> ch0 served first, then ch1 (mem_write=1, mem_wdata=16'h1234). With both re-requesting after completion, grants continue 0,1,0,1.
- Held response: mem_resp delayed 5 cycles while ch0 changes ch_address[0] mid-access -> mem_address stays at the latched value for all 5 cycles, and exactly one ch_resp pulse follows.
- Read+write both asserted on ch0: ch_read[0]=ch_write[0]=1 -> only mem_write=1.
- Reset mid-operation: rst pulsed during ISSUE -> mem_read drops immediately, no ch_resp for that access, next grant starts from channel 0.
- ARB_FIXED_PRIO_EN defined, NUM_CH=3, all three channels requesting continuously -> channel 0 granted every transaction.
